quad_encoder_multi: RTL and testbench
=====================================

// Module: quad_encoder_multi
// PURPOSE
//  Multi-channel x4 quadrature position encoder with an Avalon-MM slave for Qsys.
//  Each channel synchronises A/B/Z and decodes every edge (x4). It keeps a signed
//  modulo position, a direction flag, an illegal-transition count and an index-latched position.
//  Sits between the motor encoder pins and the Nios bus; all logic is on the bus clock.
// PARAMETERS
//  CHANNELS   4             number of encoder channels, 1..15
//  POS_WIDTH  16            position counter width, 2..32; zero-extended on read
//  ID_WORD    32'hEA680004  value returned at address 0
// PORTS
//  csi_MCLK_clk          in   1           bus/system clock, all logic on rising edge
//  rsi_MRST_reset        in   1           reset, synchronous, active-high
//  avs_ctrl_writedata    in   32          write data
//  avs_ctrl_readdata     out  32          read data, registered
//  avs_ctrl_byteenable   in   4           write byte lanes
//  avs_ctrl_address      in   6           word address
//  avs_ctrl_write        in   1           write strobe
//  avs_ctrl_read         in   1           read strobe
//  avs_ctrl_waitrequest  out  1           tied 0
//  enc_a                 in   CHANNELS    encoder phase A, asynchronous
//  enc_b                 in   CHANNELS    encoder phase B, asynchronous
//  enc_z                 in   CHANNELS    encoder index, asynchronous
// BEHAVIOUR
//  Reset
//   - Synchronous: readdata, positions, dir, err counts, latches, flags, CTRL and sync flops all 0.
//   - Reset mid-operation discards any pending edge.
//  Input path
//   - Each input passes a 2-flop synchroniser plus one history flop.
//   - Decode uses prev={a,b} and cur={a,b}, both synchronised.
//   - A pin change reaches the position 3 clocks later.
//  Decode per channel, per clock
//   - +1 steps: 00->10, 10->11, 11->01, 01->00; set dir=1.
//   - -1 steps: reverse of the above; set dir=0.
//   - Unchanged: no action.
//   - Both bits changed: position and dir unchanged, ERRCNT+1 saturating at 16'hFFFF.
//   - Position wraps modulo 2^POS_WIDTH (max+1 -> 0, 0-1 -> all ones).
//  Index handling
//   - On Z rising edge (synchronised): LATCH <= position as it was before this clock's update.
//   - Same edge sets sticky IDX flag.
//   - If CTRL.clr_en[ch]=1, position <= 0 this clock, overriding any count step.
//  Priority, same clock, same channel: bus write to POS > index clear > count step.
//  Register map, word addresses
//   - 0  ID    RO  ID_WORD.
//   - 1  CTRL  RW  [14:0] clr_en per channel; [30:16] count enable per channel.
//     Disabled channel: counts hold, but err and index still work.
//   - 4+4*ch+0  POS     RW  position; write loads it per byteenable.
//   - 4+4*ch+1  STATUS  RO/W1C  [0] dir, [1] IDX sticky (write 1 clears), [2] raw synced Z.
//   - 4+4*ch+2  ERRCNT  RW  [15:0]; any write clears to 0.
//   - 4+4*ch+3  LATCH   RO  index-latched position.
//   - Unmapped addresses and ch>=CHANNELS: read 0, writes ignored.
//  Bus timing
//   - readdata updates the clock after the address is presented (1-cycle latency), regardless of read.
//   - Writes take effect on the clock edge where write=1.
//   - W1C clearing IDX in the same clock as a new Z edge: set wins.
// TESTING
//  1. Reset, read addr 0 / 1 / 4 -> 32'hEA680004 / 0 / 0; waitrequest always 0.
//  2. Ch0, CTRL=32'h000F0000, 8 forward x4 steps -> POS0=8, STATUS0[0]=1;
//     then 10 reverse -> POS0=16'hFFFE, dir=0.
//  3. Ch1 AB jumps 00->11 three times -> ERRCNT1=3, POS1 unchanged; write ERRCNT1 -> 0.
//  4. Ch2 POS=5, clr_en[2]=0, Z pulse -> LATCH2=5, IDX=1, POS2=5;
//     clr_en[2]=1, Z with step -> POS2=0; W1C clears IDX.
//  5. Write POS3=16'h1234 in the same clock as a forward step -> POS3=16'h1234.
//  6. Reset asserted mid-rotation on all channels -> every register 0 next clock;
//     counting resumes correctly after release.

Source files
------------

// File: rtl/quad_encoder_multi.sv
// quad_encoder_multi: multi-channel x4 quadrature decoder with an Avalon-MM slave.
// Each channel synchronises A/B/Z, decodes every edge into a wrapping signed position,
// tracks direction, counts illegal (double-bit) transitions and latches position on index.
// Ports:
//   csi_MCLK_clk          bus clock, all logic on rising edge
//   rsi_MRST_reset        synchronous active-high reset
//   avs_ctrl_*            Avalon-MM slave: 6-bit word address, 32-bit data, byte enables,
//                         registered readdata (1-cycle latency), waitrequest tied 0
//   enc_a/enc_b/enc_z     asynchronous encoder phase A/B and index, one bit per channel
module quad_encoder_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned POS_WIDTH = 16,
  parameter logic [31:0] ID_WORD   = 32'hEA680004
) (
  input  logic                csi_MCLK_clk,
  input  logic                rsi_MRST_reset,
  input  logic [31:0]         avs_ctrl_writedata,
  output logic [31:0]         avs_ctrl_readdata,
  input  logic [3:0]          avs_ctrl_byteenable,
  input  logic [5:0]          avs_ctrl_address,
  input  logic                avs_ctrl_write,
  input  logic                avs_ctrl_read,
  output logic                avs_ctrl_waitrequest,
  input  logic [CHANNELS-1:0] enc_a,
  input  logic [CHANNELS-1:0] enc_b,
  input  logic [CHANNELS-1:0] enc_z
);

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ERR_W       = 16;
  localparam int unsigned CTRL_EN_LSB = 16;

  logic [CHANNELS-1:0] a_s1, a_s2, a_h;
  logic [CHANNELS-1:0] b_s1, b_s2, b_h;
  logic [CHANNELS-1:0] z_s1, z_s2, z_h;
  logic [CHANNELS-1:0] clr_en, cnt_en;
  logic [DATA_W-1:0]   wmask, ctrl_word, ctrl_wr, rd_next;
  logic [DATA_W-1:0]   rd_word [CHANNELS][4];
  logic                ctrl_sel;
  logic                bus_unused;

  // Rank of an {a,b} state along the forward sequence 00,10,11,01; rank difference mod 4
  // gives the step: 1 forward, 3 reverse, 2 illegal jump.
  function automatic logic [1:0] gray_rank(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_rank = 2'd0;
      2'b10:   gray_rank = 2'd1;
      2'b11:   gray_rank = 2'd2;
      default: gray_rank = 2'd3;
    endcase
  endfunction

  assign avs_ctrl_waitrequest = 1'b0;
  assign wmask = {{8{avs_ctrl_byteenable[3]}}, {8{avs_ctrl_byteenable[2]}},
                  {8{avs_ctrl_byteenable[1]}}, {8{avs_ctrl_byteenable[0]}}};
  assign ctrl_word = DATA_W'(clr_en) | (DATA_W'(cnt_en) << CTRL_EN_LSB);
  assign ctrl_wr   = (ctrl_word & ~wmask) | (avs_ctrl_writedata & wmask);
  assign ctrl_sel  = avs_ctrl_write && (avs_ctrl_address == 6'd1);
  // Reads have no side effects; bits of the CTRL merge beyond the channel count are dropped.
  assign bus_unused = &{1'b0, avs_ctrl_read, ctrl_wr};

  // Input synchronisers, history flops and CTRL register
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      a_s1 <= '0; a_s2 <= '0; a_h <= '0;
      b_s1 <= '0; b_s2 <= '0; b_h <= '0;
      z_s1 <= '0; z_s2 <= '0; z_h <= '0;
      clr_en <= '0;
      cnt_en <= '0;
    end else begin
      a_s1 <= enc_a; a_s2 <= a_s1; a_h <= a_s2;
      b_s1 <= enc_b; b_s2 <= b_s1; b_h <= b_s2;
      z_s1 <= enc_z; z_s2 <= z_s1; z_h <= z_s2;
      if (ctrl_sel) begin
        clr_en <= ctrl_wr[CHANNELS-1:0];
        cnt_en <= ctrl_wr[CTRL_EN_LSB +: CHANNELS];
      end
    end
  end

  // Per-channel decode, position, status, error count and index latch
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    localparam logic [3:0] GRP = 4'(ch + 1);

    logic [POS_WIDTH-1:0] pos_q, latch_q, pos_wr;
    logic [ERR_W-1:0]     err_q;
    logic                 dir_q, idx_q, sel, z_rise;
    logic [1:0]           delta;

    always_comb begin
      sel    = avs_ctrl_write && (avs_ctrl_address[5:2] == GRP);
      z_rise = z_s2[ch] && !z_h[ch];
      delta  = gray_rank({a_s2[ch], b_s2[ch]}) - gray_rank({a_h[ch], b_h[ch]});
      pos_wr = (pos_q & ~wmask[POS_WIDTH-1:0]) |
               (avs_ctrl_writedata[POS_WIDTH-1:0] & wmask[POS_WIDTH-1:0]);
    end

    always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
        pos_q   <= '0;
        latch_q <= '0;
        err_q   <= '0;
        dir_q   <= 1'b0;
        idx_q   <= 1'b0;
      end else begin
        if (z_rise) latch_q <= pos_q;

        // A new index edge beats a simultaneous W1C
        if (z_rise) idx_q <= 1'b1;
        else if (sel && (avs_ctrl_address[1:0] == 2'd1) && avs_ctrl_byteenable[0] &&
                 avs_ctrl_writedata[1]) idx_q <= 1'b0;

        if (sel && (avs_ctrl_address[1:0] == 2'd2)) err_q <= '0;
        else if ((delta == 2'd2) && (err_q != {ERR_W{1'b1}})) err_q <= err_q + ERR_W'(1);

        if (cnt_en[ch]) begin
          if (delta == 2'd1)      dir_q <= 1'b1;
          else if (delta == 2'd3) dir_q <= 1'b0;
        end

        // Bus write beats index clear beats count step
        if (sel && (avs_ctrl_address[1:0] == 2'd0)) pos_q <= pos_wr;
        else if (z_rise && clr_en[ch])              pos_q <= '0;
        else if (cnt_en[ch] && (delta == 2'd1))     pos_q <= pos_q + POS_WIDTH'(1);
        else if (cnt_en[ch] && (delta == 2'd3))     pos_q <= pos_q - POS_WIDTH'(1);
      end
    end

    assign rd_word[ch][0] = DATA_W'(pos_q);
    assign rd_word[ch][1] = DATA_W'({z_s2[ch], idx_q, dir_q});
    assign rd_word[ch][2] = DATA_W'(err_q);
    assign rd_word[ch][3] = DATA_W'(latch_q);
  end

  // Read mux; unmapped addresses and absent channels read 0
  always_comb begin
    rd_next = '0;
    if (avs_ctrl_address == 6'd0)      rd_next = ID_WORD;
    else if (avs_ctrl_address == 6'd1) rd_next = ctrl_word;
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      if (avs_ctrl_address[5:2] == 4'(ch + 1)) rd_next = rd_word[ch][avs_ctrl_address[1:0]];
    end
  end

  // Registered readdata, updated every clock from the presented address
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) avs_ctrl_readdata <= '0;
    else                avs_ctrl_readdata <= rd_next;
  end

endmodule

// File: tb/tb_quad_encoder_multi.sv
// Bench for quad_encoder_multi: directed encoder/bus stimulus, a behavioural model
// compared against readdata every cycle, and hand-computed register expectations.
module tb_quad_encoder_multi;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   wd = '0;
  logic [31:0]   rdata;
  logic [3:0]    be = 4'hF;
  logic [5:0]    addr = '0;
  logic          wr = 1'b0;
  logic          rd_stb = 1'b0;
  logic          waitreq;
  logic [CH-1:0] ea = '0, eb = '0, ez = '0;

  int checks = 0;
  int errors = 0;
  int ph[CH];

  quad_encoder_multi #(.CHANNELS(CH), .POS_WIDTH(16), .ID_WORD(32'hEA680004)) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_ctrl_writedata   (wd),
    .avs_ctrl_readdata    (rdata),
    .avs_ctrl_byteenable  (be),
    .avs_ctrl_address     (addr),
    .avs_ctrl_write       (wr),
    .avs_ctrl_read        (rd_stb),
    .avs_ctrl_waitrequest (waitreq),
    .enc_a                (ea),
    .enc_b                (eb),
    .enc_z                (ez)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // hX[k] holds the pin vector sampled k+1 clock edges ago
  bit [CH-1:0] ha[3], hb[3], hz[3];
  bit [15:0]   m_pos[CH], m_lat[CH], m_err[CH];
  bit          m_dir[CH], m_idx[CH];
  bit [31:0]   m_ctrl;
  logic [31:0] rd_exp = '0;

  // Position of an {a,b} state in the forward cycle 00 -> 10 -> 11 -> 01
  function automatic int rank(input bit a, input bit b);
    if (!a && !b) return 0;
    if (a && !b)  return 1;
    if (a && b)   return 2;
    return 3;
  endfunction

  function automatic logic [31:0] model_rd(input logic [5:0] ad);
    int c, r;
    c = int'(ad >> 2) - 1;
    r = int'(ad & 6'd3);
    if (ad == 6'd0) return 32'hEA680004;
    if (ad == 6'd1) return m_ctrl;
    if (c < 0 || c >= CH) return 32'h0;
    case (r)
      0:       return {16'h0, m_pos[c]};
      1:       return {29'h0, hz[1][c], m_idx[c], m_dir[c]};
      2:       return {16'h0, m_err[c]};
      default: return {16'h0, m_lat[c]};
    endcase
  endfunction

  always @(posedge clk) begin
    int mv, ri;
    bit zr, ws;
    bit [15:0] np;
    bit [31:0] mask, nw;
    if (rst) begin
      rd_exp = '0;
      m_ctrl = '0;
      for (int k = 0; k < 3; k++) begin ha[k] = '0; hb[k] = '0; hz[k] = '0; end
      for (int c = 0; c < CH; c++) begin
        m_pos[c] = '0; m_lat[c] = '0; m_err[c] = '0; m_dir[c] = 0; m_idx[c] = 0;
      end
    end else begin
      rd_exp = model_rd(addr);
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      ri = int'(addr & 6'd3);
      for (int c = 0; c < CH; c++) begin
        mv = (rank(ha[1][c], hb[1][c]) - rank(ha[2][c], hb[2][c]) + 4) % 4;
        zr = hz[1][c] && !hz[2][c];
        ws = wr && (int'(addr >> 2) == c + 1);
        np = m_pos[c];
        if (zr) m_lat[c] = m_pos[c];
        if (mv == 2 && m_err[c] != 16'hFFFF) m_err[c] = m_err[c] + 16'd1;
        if (ws && ri == 2) m_err[c] = '0;
        if (m_ctrl[16 + c]) begin
          if (mv == 1)      begin np = np + 16'd1; m_dir[c] = 1; end
          else if (mv == 3) begin np = np - 16'd1; m_dir[c] = 0; end
        end
        if (zr && m_ctrl[c]) np = '0;
        if (ws && ri == 0) np = (m_pos[c] & ~mask[15:0]) | (wd[15:0] & mask[15:0]);
        m_pos[c] = np;
        if (ws && ri == 1 && be[0] && wd[1]) m_idx[c] = 0;
        if (zr) m_idx[c] = 1;
      end
      if (wr && addr == 6'd1) begin
        nw = (m_ctrl & ~mask) | (wd & mask);
        m_ctrl = nw & 32'h000F_000F;
      end
      ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = ea;
      hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = eb;
      hz[2] = hz[1]; hz[1] = hz[0]; hz[0] = ez;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if (rdata !== rd_exp) begin
      errors++;
      $display("FAIL model_readdata t=%0t got %h want %h", $time, rdata, rd_exp);
    end
    checks++;
    if (waitreq !== 1'b0) begin
      errors++;
      $display("FAIL waitrequest t=%0t got %b want 0", $time, waitreq);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd_chk(input logic [5:0] a, input logic [31:0] exp, input string nm);
    addr = a;
    tick(1);
    checks++;
    if (rdata !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rdata, exp);
    end
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    addr = a; wd = d; wr = 1'b1;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic set_ab(input int c);
    case (ph[c])
      0:       begin ea[c] = 1'b0; eb[c] = 1'b0; end
      1:       begin ea[c] = 1'b1; eb[c] = 1'b0; end
      2:       begin ea[c] = 1'b1; eb[c] = 1'b1; end
      default: begin ea[c] = 1'b0; eb[c] = 1'b1; end
    endcase
  endtask

  task automatic move(input int c, input int d);
    ph[c] = (ph[c] + d + 4) % 4;
    set_ab(c);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int c = 0; c < CH; c++) ph[c] = 0;
    tick(3);
    rst = 1'b0;

    // reset state and unmapped space
    rd_chk(6'd0, 32'hEA680004, "id");
    rd_chk(6'd1, 32'h0, "ctrl_reset");
    rd_chk(6'd4, 32'h0, "pos0_reset");
    rd_chk(6'd2, 32'h0, "unmapped_2");
    bus_wr(6'd20, 32'hFFFF);
    rd_chk(6'd20, 32'h0, "absent_ch4");

    // forward then reverse counting on ch0
    bus_wr(6'd1, 32'h000F0000);
    rd_chk(6'd1, 32'h000F0000, "ctrl_rw");
    for (int i = 0; i < 8; i++) begin move(0, 1); tick(1); end
    tick(4);
    rd_chk(6'd4, 32'h8, "pos0_fwd8");
    rd_chk(6'd5, 32'h1, "status0_dir1");
    for (int i = 0; i < 10; i++) begin move(0, -1); tick(1); end
    tick(4);
    rd_chk(6'd4, 32'hFFFE, "pos0_rev10");
    rd_chk(6'd5, 32'h0, "status0_dir0");

    // illegal double-bit jumps on ch1
    ea[1] = 1'b1; eb[1] = 1'b1; tick(2);
    ea[1] = 1'b0; eb[1] = 1'b0; tick(2);
    ea[1] = 1'b1; eb[1] = 1'b1; ph[1] = 2; tick(5);
    rd_chk(6'd10, 32'h3, "err1_three");
    rd_chk(6'd8, 32'h0, "pos1_unchanged");
    bus_wr(6'd10, 32'h0);
    rd_chk(6'd10, 32'h0, "err1_cleared");

    // index latch on ch2 without and with clear
    bus_wr(6'd12, 32'h5);
    ez[2] = 1'b1; tick(4);
    ez[2] = 1'b0; tick(4);
    rd_chk(6'd15, 32'h5, "latch2");
    rd_chk(6'd13, 32'h2, "status2_idx");
    rd_chk(6'd12, 32'h5, "pos2_kept");
    bus_wr(6'd1, 32'h000F0004);
    ez[2] = 1'b1; move(2, 1); tick(5);
    rd_chk(6'd12, 32'h0, "pos2_index_clear");
    rd_chk(6'd15, 32'h5, "latch2_preclear");
    rd_chk(6'd13, 32'h7, "status2_z_high");
    ez[2] = 1'b0; tick(4);
    bus_wr(6'd13, 32'h2);
    rd_chk(6'd13, 32'h1, "status2_w1c");

    // bus write to POS3 on the same clock the step lands
    move(3, 1); tick(2);
    bus_wr(6'd16, 32'h1234);
    tick(4);
    rd_chk(6'd16, 32'h1234, "pos3_write_wins");

    // position wrap 0xFFFF -> 0 on ch1 (pins back to 00 first, counting disabled meanwhile)
    bus_wr(6'd1, 32'h0);
    ph[1] = 0; set_ab(1); tick(4);
    bus_wr(6'd1, 32'h000F0000);
    bus_wr(6'd8, 32'hFFFF);
    move(1, 1); tick(5);
    rd_chk(6'd8, 32'h0, "pos1_wrap");

    // reset landing mid-rotation on all channels; model tracks recovery
    addr = 6'd4;
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < CH; c++) move(c, 1);
      if (i == 5) rst = 1'b1;
      if (i == 6) rst = 1'b0;
      if (i == 7) bus_wr(6'd1, 32'h000F0000);
      else tick(1);
      addr = 6'd4;
    end
    tick(4);

    // clean reset with pins idle: everything zero, counting restarts
    rst = 1'b1;
    for (int c = 0; c < CH; c++) begin ph[c] = 0; set_ab(c); end
    ez = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    rd_chk(6'd1, 32'h0, "ctrl_after_reset");
    rd_chk(6'd4, 32'h0, "pos0_after_reset");
    rd_chk(6'd13, 32'h0, "status2_after_reset");
    rd_chk(6'd15, 32'h0, "latch2_after_reset");
    bus_wr(6'd1, 32'h000F0000);
    for (int i = 0; i < 3; i++) begin move(0, 1); tick(1); end
    tick(4);
    rd_chk(6'd4, 32'h3, "pos0_resumed");
    rd_chk(6'd5, 32'h1, "status0_resumed");

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
